jtag_tap_port: RTL
==================

// Module: jtag_tap_port
// PURPOSE
//  - JTAG test-access front end that drives functional_unit and reads it back.
//  - Embeds a 16-state IEEE 1149.1 TAP controller and a 2-bit IR.
//  - Data registers: IDCODE, XREG (stimulus X[3:0]), YREG (capture of Yin[3:0]) and BYPASS.
//  - Outputs TLR and X feed functional_unit; its Yin returns here and is shifted out on TDO.
// PARAMETERS
//  ID_WIDTH   8      width of the IDCODE register
//  IDCODE     8'hA5  value loaded into IDCODE at Capture-DR
// PORTS
//  clk     in   1         TCK; TAP state and shifts on posedge, TDO/update on negedge
//  rst_n   in   1         async active-low reset (TRST equivalent)
//  TMS     in   1         test mode select, sampled on posedge
//  TDI     in   1         serial data in, sampled on posedge
//  Yin     in   4         functional_unit state, captured in Capture-DR under YREG
//  TLR     out  1         high while TAP is in Test-Logic-Reset
//  X       out  4         update register driving functional_unit.X
//  TDO     out  1         serial data out, changes on negedge
//  TDO_EN  out  1         high on negedge while in Shift-IR/Shift-DR
// BEHAVIOUR
//  - Reset (rst_n=0, async): TAP=TEST_LOGIC_RESET, TLR=1, IR=IDCODE(2'b00), X=0, TDO=0,
//    TDO_EN=0, all shift registers 0. Reset mid-shift aborts the shift; X does not update.
//  - TAP: standard 16-state graph on posedge from TMS.
//    TLR-(0)->RTI; RTI-(1)->SelDR-(1)->SelIR-(1)->TLR;
//    Capture->(0)Shift/(1)Exit1; Shift-(1)->Exit1-(0)->Pause-(1)->Exit2-(0)->Shift;
//    Exit1/Exit2-(1)->Update-(0)->RTI / (1)->SelDR.
//  - Five consecutive TMS=1 posedges reach TLR from any state.
//  - TLR output: combinational decode of state==TEST_LOGIC_RESET. It is stable at the
//    functional_unit negedge sample point.
//  - While in TLR: IR forced to IDCODE, X forced to 0.
//  - IR opcodes: 00 IDCODE, 01 XREG, 10 YREG, 11 BYPASS.
//  - IR path: Capture-IR loads shift reg with 2'b01.
//    Every posedge in Shift-IR: sr <= {TDI, sr[1]}.
//    Update-IR: IR <= sr on negedge.
//  - DR path (selected by IR, length L):
//    - Capture-DR loads: IDCODE -> IDCODE (L=ID_WIDTH); XREG -> current X (L=4);
//      YREG -> Yin (L=4); BYPASS -> 0 (L=1).
//    - Shift-DR: LSB out first, TDI enters MSB, one bit per posedge in Shift-DR.
//    - The edge leaving Shift (TMS=1) still shifts.
//  - Update-DR with IR=XREG: X <= dr_sr[3:0] on the negedge in Update-DR.
//    X holds its value through Capture/Shift/Pause/Exit.
//  - TDO: on negedge, TDO <= active sr[0] and TDO_EN <= 1 if in Shift-IR/Shift-DR.
//    Otherwise TDO_EN <= 0 and TDO holds.
//  - Latency: first TDO bit valid at the negedge after entering Shift.
//    X changes at the negedge of the Update-DR cycle.
//    functional_unit sees the new X at that same negedge.
// STRUCTURE
//  - Package jtag_pkg: 4-bit TAP state localparams (TLR, RTI, SELDR, CAPDR, SHDR,
//    EX1DR, PSDR, EX2DR, UPDR, SELIR, CAPIR, SHIR, EX1IR, PSIR, EX2IR, UPIR);
//    IR opcodes; IR_WIDTH=2.
//  - Sub-module jtag_tap_controller: clk, rst_n, TMS -> state, plus decoded
//    capture/shift/update strobes for DR and IR.
//  - Top holds IR, DR shift muxing, X update register and TDO negedge flop.
// TESTING
//  1. rst_n=0 mid-Shift-DR -> immediately TLR=1, X=0, TDO_EN=0, IR=00.
//  2. From Shift-DR, TMS=1 x5 -> TLR=1 after the 5th posedge; X cleared to 0.
//  3. Reset, TMS 0,1,0,0 then 8 shifts -> TDO 1,0,1,0,0,1,0,1 (8'hA5 LSB-first).
//  4. Load IR=01, shift-DR TDI 1,0,1,1 then Update-DR -> X=4'b1101 at Update negedge.
//     X is unchanged during the shift; functional_unit from STATE_0 stays 0.
//  5. IR=10 with Yin=4'hC at Capture-DR -> TDO 0,0,1,1.
//     Yin changing during the shift does not alter the output.
//  6. IR=11, shift TDI 1,1,0,1 -> TDO 0,1,1,0 (one-bit delay).
//     Pause-DR/Exit2 round-trip mid-shift preserves the sequence.

Source files
------------

// File: rtl/jtag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtag_pkg                                                         |
// | Purpose : Shared constants for the JTAG test-access front end: 4-bit TAP   |
// |           state encodings, instruction register width and opcodes.         |
// | Ports   : none (package)                                                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package jtag_pkg;

   localparam int IR_WIDTH = 2;

   typedef logic [3:0]          tap_state_t;
   typedef logic [IR_WIDTH-1:0] ir_t;

   // TAP controller states
   localparam tap_state_t TLR   = 4'd0;
   localparam tap_state_t RTI   = 4'd1;
   localparam tap_state_t SELDR = 4'd2;
   localparam tap_state_t CAPDR = 4'd3;
   localparam tap_state_t SHDR  = 4'd4;
   localparam tap_state_t EX1DR = 4'd5;
   localparam tap_state_t PSDR  = 4'd6;
   localparam tap_state_t EX2DR = 4'd7;
   localparam tap_state_t UPDR  = 4'd8;
   localparam tap_state_t SELIR = 4'd9;
   localparam tap_state_t CAPIR = 4'd10;
   localparam tap_state_t SHIR  = 4'd11;
   localparam tap_state_t EX1IR = 4'd12;
   localparam tap_state_t PSIR  = 4'd13;
   localparam tap_state_t EX2IR = 4'd14;
   localparam tap_state_t UPIR  = 4'd15;

   // Instruction opcodes
   localparam ir_t IR_IDCODE = 2'b00;
   localparam ir_t IR_XREG   = 2'b01;
   localparam ir_t IR_YREG   = 2'b10;
   localparam ir_t IR_BYPASS = 2'b11;

   // Fixed pattern loaded into the IR shift register at Capture-IR
   localparam ir_t IR_CAPTURE = 2'b01;

endpackage
`default_nettype wire

// File: rtl/jtag_tap_controller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtag_tap_controller                                              |
// | Purpose : 16-state IEEE 1149.1 TAP state machine advanced by TMS on the    |
// |           rising TCK edge, with decoded capture/shift/update strobes.      |
// | Ports   : clk          in  TCK                                             |
// |           rst_n        in  async active-low reset (TRST)                   |
// |           TMS          in  test mode select                                |
// |           o_state      out current TAP state                               |
// |           o_capture_dr/o_shift_dr/o_update_dr  out DR-column strobes       |
// |           o_capture_ir/o_shift_ir/o_update_ir  out IR-column strobes       |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtag_tap_controller
   import jtag_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       TMS,
   output logic [3:0] o_state,
   output logic       o_capture_dr,
   output logic       o_shift_dr,
   output logic       o_update_dr,
   output logic       o_capture_ir,
   output logic       o_shift_ir,
   output logic       o_update_ir
);

   tap_state_t r_state;
   tap_state_t w_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= TLR;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = TLR;
      case (r_state)
         TLR   : w_next = TMS ? TLR   : RTI;
         RTI   : w_next = TMS ? SELDR : RTI;
         SELDR : w_next = TMS ? SELIR : CAPDR;
         CAPDR : w_next = TMS ? EX1DR : SHDR;
         SHDR  : w_next = TMS ? EX1DR : SHDR;
         EX1DR : w_next = TMS ? UPDR  : PSDR;
         PSDR  : w_next = TMS ? EX2DR : PSDR;
         EX2DR : w_next = TMS ? UPDR  : SHDR;
         UPDR  : w_next = TMS ? SELDR : RTI;
         SELIR : w_next = TMS ? TLR   : CAPIR;
         CAPIR : w_next = TMS ? EX1IR : SHIR;
         SHIR  : w_next = TMS ? EX1IR : SHIR;
         EX1IR : w_next = TMS ? UPIR  : PSIR;
         PSIR  : w_next = TMS ? EX2IR : PSIR;
         EX2IR : w_next = TMS ? UPIR  : SHIR;
         UPIR  : w_next = TMS ? SELDR : RTI;
         default: w_next = TLR;
      endcase
   end

   assign o_state      = r_state;
   assign o_capture_dr = (r_state == CAPDR);
   assign o_shift_dr   = (r_state == SHDR);
   assign o_update_dr  = (r_state == UPDR);
   assign o_capture_ir = (r_state == CAPIR);
   assign o_shift_ir   = (r_state == SHIR);
   assign o_update_ir  = (r_state == UPIR);

endmodule
`default_nettype wire

// File: rtl/jtag_tap_port.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : jtag_tap_port                                                    |
// | Purpose : JTAG front end driving functional_unit: TAP controller, 2-bit    |
// |           IR, IDCODE/XREG/YREG/BYPASS data registers, negedge TDO.         |
// | Ports   : clk     in  TCK (state/shift on posedge, TDO/update on negedge)  |
// |           rst_n   in  async active-low reset (TRST)                        |
// |           TMS     in  test mode select                                     |
// |           TDI     in  serial data in                                       |
// |           Yin[3:0] in functional_unit state, captured under YREG          |
// |           TLR     out high while TAP is in Test-Logic-Reset                |
// |           X[3:0]  out update register feeding functional_unit.X            |
// |           TDO     out serial data out                                      |
// |           TDO_EN  out high while shifting IR or DR                         |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module jtag_tap_port #(
   parameter int                  ID_WIDTH = 8,
   parameter logic [ID_WIDTH-1:0] IDCODE   = 8'hA5
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       TMS,
   input  logic       TDI,
   input  logic [3:0] Yin,
   output logic       TLR,
   output logic [3:0] X,
   output logic       TDO,
   output logic       TDO_EN
);
   import jtag_pkg::*;

   logic [3:0]          w_state;
   logic                w_capture_dr, w_shift_dr, w_update_dr;
   logic                w_capture_ir, w_shift_ir, w_update_ir;
   logic                w_tlr;

   ir_t                 r_ir;
   ir_t                 r_ir_sr;
   logic [ID_WIDTH-1:0] r_dr_sr;
   logic [3:0]          r_x;
   logic                r_tdo;
   logic                r_tdo_en;

   int                  w_dr_len;
   logic [ID_WIDTH-1:0] w_dr_capture;
   logic [ID_WIDTH-1:0] w_dr_down;
   logic [ID_WIDTH-1:0] w_dr_shift;

   jtag_tap_controller u_ctrl (
      .clk          (clk),
      .rst_n        (rst_n),
      .TMS          (TMS),
      .o_state      (w_state),
      .o_capture_dr (w_capture_dr),
      .o_shift_dr   (w_shift_dr),
      .o_update_dr  (w_update_dr),
      .o_capture_ir (w_capture_ir),
      .o_shift_ir   (w_shift_ir),
      .o_update_ir  (w_update_ir)
   );

   // Combinational decode keeps TLR settled well before the negedge sample.
   assign w_tlr = (w_state == jtag_pkg::TLR);

   // ---------------------------------------------------------------- IR path
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_ir_sr <= '0;
      else if (w_capture_ir) r_ir_sr <= IR_CAPTURE;
      else if (w_shift_ir)   r_ir_sr <= {TDI, r_ir_sr[IR_WIDTH-1]};
   end

   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)           r_ir <= IR_IDCODE;
      else if (w_tlr)       r_ir <= IR_IDCODE;
      else if (w_update_ir) r_ir <= r_ir_sr;
   end

   // ---------------------------------------------------------------- DR path
   // One physical shift register serves every DR; the active length decides
   // which bit TDI lands in so the selected register behaves as L bits wide.
   always_comb begin
      w_dr_len = 1;
      case (r_ir)
         IR_IDCODE: w_dr_len = ID_WIDTH;
         IR_XREG  : w_dr_len = 4;
         IR_YREG  : w_dr_len = 4;
         default  : w_dr_len = 1;
      endcase
   end

   always_comb begin
      w_dr_capture = '0;
      case (r_ir)
         IR_IDCODE: w_dr_capture = IDCODE;
         IR_XREG  : w_dr_capture = {{(ID_WIDTH-4){1'b0}}, r_x};
         IR_YREG  : w_dr_capture = {{(ID_WIDTH-4){1'b0}}, Yin};
         default  : w_dr_capture = '0;
      endcase
   end

   assign w_dr_down = r_dr_sr >> 1;

   always_comb begin
      w_dr_shift = '0;
      for (int i = 0; i < ID_WIDTH; i++) begin
         if (i == w_dr_len - 1)     w_dr_shift[i] = TDI;
         else if (i < w_dr_len - 1) w_dr_shift[i] = w_dr_down[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            r_dr_sr <= '0;
      else if (w_capture_dr) r_dr_sr <= w_dr_capture;
      else if (w_shift_dr)   r_dr_sr <= w_dr_shift;
   end

   // -------------------------------------------------------- X update register
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n)                              r_x <= '0;
      else if (w_tlr)                          r_x <= '0;
      else if (w_update_dr && r_ir == IR_XREG) r_x <= r_dr_sr[3:0];
   end

   // ----------------------------------------------------------- TDO negedge flop
   always_ff @(negedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tdo    <= 1'b0;
         r_tdo_en <= 1'b0;
      end else if (w_shift_ir) begin
         r_tdo    <= r_ir_sr[0];
         r_tdo_en <= 1'b1;
      end else if (w_shift_dr) begin
         r_tdo    <= r_dr_sr[0];
         r_tdo_en <= 1'b1;
      end else begin
         r_tdo_en <= 1'b0;
      end
   end

   assign TLR    = w_tlr;
   assign X      = r_x;
   assign TDO    = r_tdo;
   assign TDO_EN = r_tdo_en;

endmodule
`default_nettype wire
